vector_seq: RTL and testbench

- Reader/sequencer for the vector-image ROMs.
- On a start request it walks a ROM object from a given start address, one 18-bit entry at a time. Each entry is {x[7:0], y[7:0], line, pos}.
- Each point is presented to the downstream beam/line-drawer over a valid/ready handshake, with a per-object x/y offset applied.
- The object ends at its end marker (line=1, pos=1). The block can optionally loop the object continuously for display refresh.

---
 rtl/vector_seq.sv | 188 ++++++++++++++++++
 tb/tb_vector_seq.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vector_seq.sv
// Vector-image ROM sequencer: walks an object's {x, y, line, pos} entries and presents offset
// points over valid/ready. Optional point watchdog enabled by defining VECTOR_SEQ_WATCHDOG_EN.
module vector_seq #(
  parameter int unsigned ADDRESSWIDTH = 16,
  parameter int unsigned DATAWIDTH    = 18,
  parameter int unsigned MAX_POINTS   = 256
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [ADDRESSWIDTH-1:0] start_addr,
  input  logic                    loop,
  input  logic                    stop,
  input  logic [7:0]              x_off,
  input  logic [7:0]              y_off,
  output logic [ADDRESSWIDTH-1:0] rom_addr,
  input  logic [DATAWIDTH-1:0]    rom_data,
  output logic                    pt_valid,
  input  logic                    pt_ready,
  output logic [7:0]              pt_x,
  output logic [7:0]              pt_y,
  output logic                    pt_draw,
  output logic                    pt_last,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] FETCH   = 2'd1;
  localparam logic [1:0] PRESENT = 2'd2;
  localparam logic [1:0] DONE    = 2'd3;

  logic [1:0]              state_q, state_d;
  logic [ADDRESSWIDTH-1:0] ptr_q, ptr_d;
  logic [ADDRESSWIDTH-1:0] base_q, base_d;
  logic                    loop_q, loop_d;
  logic [7:0]              xoff_q, xoff_d;
  logic [7:0]              yoff_q, yoff_d;
  logic [7:0]              px_q, px_d;
  logic [7:0]              py_q, py_d;
  logic                    pdraw_q, pdraw_d;
  logic                    plast_q, plast_d;
  logic                    err_q, err_d;

  logic hs;
  logic job_start;
  logic pass_restart;
  logic wd_abort;

  assign hs           = (state_q == PRESENT) && pt_ready;
  assign job_start    = (state_q == IDLE) && start;
  assign pass_restart = hs && plast_q && loop_q && !stop;

`ifdef VECTOR_SEQ_WATCHDOG_EN
  localparam int unsigned CntW = $clog2(MAX_POINTS + 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (job_start || pass_restart) begin
      cnt_d = '0;
    end else if (hs) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Abort on the handshake that would be point number MAX_POINTS without an end marker.
  assign wd_abort = hs && !plast_q && (cnt_q == CntW'(MAX_POINTS - 1));
`else
  logic unused_max_points;
  assign unused_max_points = (MAX_POINTS == 0);
  assign wd_abort          = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    base_d  = base_q;
    loop_d  = loop_q;
    xoff_d  = xoff_q;
    yoff_d  = yoff_q;
    px_d    = px_q;
    py_d    = py_q;
    pdraw_d = pdraw_q;
    plast_d = plast_q;
    err_d   = err_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          base_d  = start_addr;
          ptr_d   = start_addr;
          loop_d  = loop;
          xoff_d  = x_off;
          yoff_d  = y_off;
          err_d   = 1'b0;
          state_d = FETCH;
        end
      end
      FETCH: begin
        px_d    = rom_data[DATAWIDTH-1 -: 8] + xoff_q;
        py_d    = rom_data[DATAWIDTH-9 -: 8] + yoff_q;
        pdraw_d = rom_data[1] & ~rom_data[0];
        plast_d = rom_data[1] & rom_data[0];
        state_d = PRESENT;
      end
      PRESENT: begin
        if (pt_ready) begin
          if (!plast_q) begin
            if (wd_abort) begin
              err_d   = 1'b1;
              loop_d  = 1'b0;
              state_d = DONE;
            end else begin
              ptr_d   = ptr_q + ADDRESSWIDTH'(1);
              state_d = FETCH;
            end
          end else if (pass_restart) begin
            ptr_d   = base_q;
            xoff_d  = x_off;
            yoff_d  = y_off;
            state_d = FETCH;
          end else begin
            state_d = DONE;
          end
        end
      end
      default: begin
        loop_d  = 1'b0;
        state_d = IDLE;
      end
    endcase

    // stop cancels looping for the rest of the job but lets the current pass finish.
    if (stop && (state_q != IDLE)) begin
      loop_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      base_q  <= '0;
      loop_q  <= 1'b0;
      xoff_q  <= '0;
      yoff_q  <= '0;
      px_q    <= '0;
      py_q    <= '0;
      pdraw_q <= 1'b0;
      plast_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      base_q  <= base_d;
      loop_q  <= loop_d;
      xoff_q  <= xoff_d;
      yoff_q  <= yoff_d;
      px_q    <= px_d;
      py_q    <= py_d;
      pdraw_q <= pdraw_d;
      plast_q <= plast_d;
      err_q   <= err_d;
    end
  end

  assign rom_addr = ptr_q;
  assign pt_valid = (state_q == PRESENT);
  assign pt_x     = px_q;
  assign pt_y     = py_q;
  assign pt_draw  = pdraw_q;
  assign pt_last  = plast_q;
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);
  assign err      = err_q;

endmodule

// File: tb/tb_vector_seq.sv
// Directed bench for vector_seq: combinational ROM model, handshake timing, offsets, backpressure,
// loop/stop, start-while-busy, reset mid-pass, address wrap and (when enabled) the watchdog.
module tb_vector_seq;

  logic        clk, rst, start, loop, stop, pt_ready;
  logic [15:0] start_addr, rom_addr;
  logic [17:0] rom_data;
  logic [7:0]  x_off, y_off, pt_x, pt_y;
  logic        pt_valid, pt_draw, pt_last, busy, done, err;

  int n_tests = 0;
  int n_fail  = 0;

  int bx[6] = '{0, 0, 255, 255, 0, 0};
  int by[6] = '{255, 0, 0, 255, 255, 255};
  int bd[6] = '{0, 1, 1, 1, 1, 0};
  int bl[6] = '{0, 0, 0, 0, 0, 1};

  function automatic logic [17:0] rom_f(input logic [15:0] a);
    case (a)
      16'd42:   rom_f = {8'd0,   8'd255, 2'b01};
      16'd43:   rom_f = {8'd0,   8'd0,   2'b10};
      16'd44:   rom_f = {8'd255, 8'd0,   2'b10};
      16'd45:   rom_f = {8'd255, 8'd255, 2'b10};
      16'd46:   rom_f = {8'd0,   8'd255, 2'b10};
      16'd47:   rom_f = {8'd0,   8'd255, 2'b11};
      16'hFFFF: rom_f = {8'd1,   8'd2,   2'b10};
      16'h0000: rom_f = {8'd3,   8'd4,   2'b11};
      default:  rom_f = {8'h11,  8'h22,  2'b10};
    endcase
  endfunction

  assign rom_data = rom_f(rom_addr);

  vector_seq dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .start_addr(start_addr),
    .loop      (loop),
    .stop      (stop),
    .x_off     (x_off),
    .y_off     (y_off),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .pt_valid  (pt_valid),
    .pt_ready  (pt_ready),
    .pt_x      (pt_x),
    .pt_y      (pt_y),
    .pt_draw   (pt_draw),
    .pt_last   (pt_last),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

`ifdef VECTOR_SEQ_WATCHDOG_EN
  logic        wd_start, wd_loop, wd_valid, wd_draw, wd_last, wd_busy, wd_done, wd_err;
  logic [15:0] wd_start_addr, wd_rom_addr;
  logic [17:0] wd_rom_data;
  logic [7:0]  wd_x, wd_y;

  assign wd_rom_data = rom_f(wd_rom_addr);

  vector_seq #(.MAX_POINTS(4)) dut_wd (
    .clk       (clk),
    .rst       (rst),
    .start     (wd_start),
    .start_addr(wd_start_addr),
    .loop      (wd_loop),
    .stop      (1'b0),
    .x_off     (8'd0),
    .y_off     (8'd0),
    .rom_addr  (wd_rom_addr),
    .rom_data  (wd_rom_data),
    .pt_valid  (wd_valid),
    .pt_ready  (1'b1),
    .pt_x      (wd_x),
    .pt_y      (wd_y),
    .pt_draw   (wd_draw),
    .pt_last   (wd_last),
    .busy      (wd_busy),
    .done      (wd_done),
    .err       (wd_err)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic [15:0] a, input logic lp, input logic [7:0] xo, yo);
    start_addr = a;
    loop       = lp;
    x_off      = xo;
    y_off      = yo;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_rom_addr", rom_addr, a);
    chk("start_no_valid", pt_valid, 0);
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (pt_valid !== 1'b1 && n < 40);
    chk("valid_timeout", pt_valid, 1);
  endtask

  task automatic check_pt(input string tag, input int i, input logic [7:0] xo, yo);
    logic [7:0] ex, ey;
    ex = 8'(bx[i]) + xo;
    ey = 8'(by[i]) + yo;
    chk($sformatf("%s_p%0d_x", tag, i), pt_x, ex);
    chk($sformatf("%s_p%0d_y", tag, i), pt_y, ey);
    chk($sformatf("%s_p%0d_draw", tag, i), pt_draw, bd[i]);
    chk($sformatf("%s_p%0d_last", tag, i), pt_last, bl[i]);
  endtask

  // Checks points lo..hi; after the first, each must arrive exactly 2 cycles after the previous.
  task automatic run_pts(input string tag, input int lo, hi, input logic [7:0] xo, yo,
                         input int first_n);
    int n;
    for (int i = lo; i <= hi; i++) begin
      wait_valid(n);
      if (i != lo) chk($sformatf("%s_p%0d_gap", tag, i), n, 2);
      else if (first_n > 0) chk($sformatf("%s_latency", tag), n, first_n);
      check_pt(tag, i, xo, yo);
    end
  endtask

  task automatic finish_done(input string tag);
    @(negedge clk);
    chk({tag, "_done_pulse"}, done, 1);
    chk({tag, "_done_busy"}, busy, 1);
    chk({tag, "_done_novalid"}, pt_valid, 0);
    @(negedge clk);
    chk({tag, "_done_low"}, done, 0);
    chk({tag, "_idle_busy"}, busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1);
  end

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; loop = 1'b0; stop = 1'b0; pt_ready = 1'b1;
    start_addr = '0; x_off = '0; y_off = '0;
`ifdef VECTOR_SEQ_WATCHDOG_EN
    wd_start = 1'b0; wd_loop = 1'b0; wd_start_addr = '0;
`endif
    repeat (2) @(negedge clk);
    chk("rst_valid", pt_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_rom_addr", rom_addr, 0);
    chk("rst_pt", {pt_x, pt_y, pt_draw, pt_last}, 0);
    rst = 1'b0;
    @(negedge clk);

    // Basic pass, no offsets.
    do_start(16'd42, 1'b0, 8'd0, 8'd0);
    run_pts("basic", 0, 5, 8'd0, 8'd0, 1);
    finish_done("basic");

    // Offsets with modulo-256 wrap.
    do_start(16'd42, 1'b0, 8'd10, 8'd5);
    run_pts("off", 0, 5, 8'd10, 8'd5, 1);
    finish_done("off");

    // Backpressure on point 3.
    do_start(16'd42, 1'b0, 8'd0, 8'd0);
    run_pts("bp", 0, 1, 8'd0, 8'd0, 1);
    @(negedge clk);
    pt_ready = 1'b0;
    @(negedge clk);
    check_pt("bp", 2, 8'd0, 8'd0);
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      chk($sformatf("bp_hold%0d_valid", k), pt_valid, 1);
      chk($sformatf("bp_hold%0d_xy", k), {pt_x, pt_y}, {8'd255, 8'd0});
      chk($sformatf("bp_hold%0d_addr", k), rom_addr, 16'd44);
    end
    pt_ready = 1'b1;
    run_pts("bp", 3, 5, 8'd0, 8'd0, 0);
    finish_done("bp");

    // Loop mode: x_off re-sampled at the pass restart, stop ends after pass 2.
    do_start(16'd42, 1'b1, 8'd0, 8'd0);
    x_off = 8'd20;
    run_pts("lp1", 0, 5, 8'd0, 8'd0, 1);
    @(negedge clk);
    chk("lp_restart_done", done, 0);
    chk("lp_restart_busy", busy, 1);
    chk("lp_restart_addr", rom_addr, 16'd42);
    run_pts("lp2", 0, 2, 8'd20, 8'd0, 1);
    stop = 1'b1;
    run_pts("lp2", 3, 5, 8'd20, 8'd0, 0);
    finish_done("lp2");
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("lp_no_pass3_%0d", k), {busy, pt_valid}, 2'b00);
    end
    stop = 1'b0;
    x_off = 8'd0;

    // start while busy is ignored.
    do_start(16'd42, 1'b0, 8'd0, 8'd0);
    run_pts("sb", 0, 0, 8'd0, 8'd0, 1);
    start_addr = 16'd100;
    start = 1'b1;
    wait_valid(n);
    start = 1'b0;
    check_pt("sb", 1, 8'd0, 8'd0);
    run_pts("sb", 2, 5, 8'd0, 8'd0, 0);
    finish_done("sb");

    // Reset while presenting a point.
    do_start(16'd42, 1'b0, 8'd0, 8'd0);
    pt_ready = 1'b0;
    run_pts("rs", 0, 0, 8'd0, 8'd0, 1);
    rst = 1'b1;
    #1;
    chk("rs_async_valid", pt_valid, 0);
    chk("rs_async_busy", busy, 0);
    chk("rs_async_done", done, 0);
    @(negedge clk);
    chk("rs_no_done", done, 0);
    rst = 1'b0;
    pt_ready = 1'b1;
    @(negedge clk);
    do_start(16'd42, 1'b0, 8'd0, 8'd0);
    run_pts("rs2", 0, 5, 8'd0, 8'd0, 1);
    finish_done("rs2");

    // Address wrap from 16'hFFFF to 0.
    do_start(16'hFFFF, 1'b0, 8'd0, 8'd0);
    wait_valid(n);
    chk("wrap_p0", {pt_x, pt_y, pt_draw, pt_last}, {8'd1, 8'd2, 2'b10});
    wait_valid(n);
    chk("wrap_addr", rom_addr, 16'h0000);
    chk("wrap_p1", {pt_x, pt_y, pt_draw, pt_last}, {8'd3, 8'd4, 2'b01});
    finish_done("wrap");

    // Object without an end marker keeps walking with err low.
    do_start(16'd100, 1'b0, 8'd0, 8'd0);
    for (int k = 0; k < 6; k++) begin
      wait_valid(n);
      chk($sformatf("noend%0d_last", k), pt_last, 0);
      chk($sformatf("noend%0d_err", k), err, 0);
      chk($sformatf("noend%0d_addr", k), rom_addr, 16'd100 + 16'(k));
    end
    @(negedge clk);
    chk("noend_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

`ifdef VECTOR_SEQ_WATCHDOG_EN
    // Watchdog with MAX_POINTS=4, loop requested: aborts after 4 handshakes, no restart.
    wd_start_addr = 16'd100;
    wd_loop = 1'b1;
    wd_start = 1'b1;
    @(negedge clk);
    wd_start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (wd_valid !== 1'b1 && n < 40);
      chk($sformatf("wd_p%0d_valid", k), wd_valid, 1);
      chk($sformatf("wd_p%0d_xy", k), {wd_x, wd_y}, {8'h11, 8'h22});
    end
    @(negedge clk);
    chk("wd_done", wd_done, 1);
    chk("wd_err", wd_err, 1);
    @(negedge clk);
    chk("wd_idle", {wd_busy, wd_valid, wd_done}, 3'b000);
    chk("wd_err_held", wd_err, 1);
    wd_start_addr = 16'hFFFF;
    wd_loop = 1'b0;
    wd_start = 1'b1;
    @(negedge clk);
    wd_start = 1'b0;
    chk("wd_err_cleared", wd_err, 0);
    repeat (5) @(negedge clk);
    chk("wd_short_idle", wd_busy, 0);
    chk("wd_short_err", wd_err, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
